alu_op_sequencer: RTL

Issue-side controller for the 16-bit ALU. It accepts one operation request through a valid/ready handshake and drives the ALU operands and control lines (f, fsel, csel, ucin, fcin, fyoe). It waits a fixed settle time, captures y/cout/zout, and keeps the persistent C/Z status flags, feeding C back as fcin. It returns the result through a valid/ready response handshake.

---
 rtl/alu_op_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue-side controller for the 16-bit ALU.
//
// Takes one operation request over a valid/ready handshake and drives the ALU operands and
// control lines. It holds the result output enable for SETTLE_CYCLES cycles, then captures
// y/cout/zout. The persistent C/Z status flags live here, and C is fed back to the ALU as
// fcin. The result leaves through a valid/ready response handshake.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     request handshake; accepted on a clock edge when both are high
//   req_op/a/b              opcode (0..9 legal, 10..15 illegal) and operands
//   req_use_carry/req_ucin  carry source select and microsequencer carry
//   alu_a/alu_b/alu_f       latched operands and function code
//   alu_fsel/alu_csel       function unit select and carry-in select
//   alu_ucin/alu_fcin       microsequencer carry, flag carry
//   alu_fyoe                ALU result output enable (high only while driving)
//   alu_y/alu_cout/alu_zout ALU result bus, carry out and zero out
//   rsp_valid/rsp_ready     response handshake
//   rsp_y/rsp_err           captured result, illegal-opcode indication
//   flag_c/flag_z           status flags
//   flags_clr               synchronous clear of both flags
//
// Function code encoding: alu_f = {M, S[3:0]} of a 74181-style unit in 74181 mode, and a
// shift direction (0 = left, 1 = right) in shift mode.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_use_carry,
  input  logic        req_ucin,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_f,
  output logic        alu_fsel,
  output logic        alu_csel,
  output logic        alu_ucin,
  output logic        alu_fcin,
  output logic        alu_fyoe,
  input  logic [15:0] alu_y,
  input  logic        alu_cout,
  input  logic        alu_zout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_y,
  output logic        rsp_err,
  output logic        flag_c,
  output logic        flag_z,
  input  logic        flags_clr
);

  localparam logic [4:0] ALU_F_PASSA = 5'b0_0000;  // A plus Cn
  localparam logic [4:0] ALU_F_SUB   = 5'b0_0110;  // A minus B minus 1 plus Cn
  localparam logic [4:0] ALU_F_ADD   = 5'b0_1001;  // A plus B plus Cn
  localparam logic [4:0] ALU_F_PASSB = 5'b1_1010;
  localparam logic [4:0] ALU_F_NOT   = 5'b1_0000;
  localparam logic [4:0] ALU_F_XOR   = 5'b1_0110;
  localparam logic [4:0] ALU_F_AND   = 5'b1_1011;
  localparam logic [4:0] ALU_F_OR    = 5'b1_1110;
  localparam logic [4:0] ALU_F_SHL   = 5'b0_0000;
  localparam logic [4:0] ALU_F_SHR   = 5'b0_0001;

  localparam logic ALU_FSEL_74181 = 1'b0;
  localparam logic ALU_FSEL_SHIFT = 1'b1;

  localparam int unsigned CntW = 4;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gen_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic [4:0]        f_q, f_d;
  logic              fsel_q, fsel_d;
  logic              csel_q, csel_d;
  logic              ucin_q, ucin_d;
  logic              upd_c_q, upd_c_d;  // op writes flag_c at capture
  logic [15:0]       rsp_y_q, rsp_y_d;
  logic              rsp_err_q, rsp_err_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;

  // Opcode decode
  logic [4:0] op_f;
  logic       op_fsel;
  logic       op_legal;
  logic       op_upd_c;

  always_comb begin
    op_f     = ALU_F_PASSA;
    op_fsel  = ALU_FSEL_74181;
    op_legal = 1'b1;
    op_upd_c = 1'b0;
    case (req_op)
      4'd0: begin op_f = ALU_F_PASSA; op_upd_c = 1'b1; end
      4'd1: op_f = ALU_F_PASSB;
      4'd2: begin op_f = ALU_F_SUB; op_upd_c = 1'b1; end
      4'd3: begin op_f = ALU_F_ADD; op_upd_c = 1'b1; end
      4'd4: op_f = ALU_F_NOT;
      4'd5: op_f = ALU_F_XOR;
      4'd6: op_f = ALU_F_AND;
      4'd7: op_f = ALU_F_OR;
      4'd8: begin op_f = ALU_F_SHL; op_fsel = ALU_FSEL_SHIFT; end
      4'd9: begin op_f = ALU_F_SHR; op_fsel = ALU_FSEL_SHIFT; end
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    f_d       = f_q;
    fsel_d    = fsel_q;
    csel_d    = csel_q;
    ucin_d    = ucin_q;
    upd_c_d   = upd_c_q;
    rsp_y_d   = rsp_y_q;
    rsp_err_d = rsp_err_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;

    // Clear first so a capture on the same edge overrides it.
    if (flags_clr) begin
      flag_c_d = 1'b0;
      flag_z_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d    = req_a;
          b_d    = req_b;
          ucin_d = req_ucin;
          csel_d = req_use_carry;
          if (op_legal) begin
            f_d     = op_f;
            fsel_d  = op_fsel;
            upd_c_d = op_upd_c;
            cnt_d   = CntW'(SETTLE_CYCLES - 1);
            state_d = StDrive;
          end else begin
            // Never drive the ALU for an illegal op; answer straight away.
            rsp_y_d   = 16'h0000;
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          rsp_y_d   = alu_y;
          rsp_err_d = 1'b0;
          flag_z_d  = alu_zout;
          if (upd_c_q) flag_c_d = alu_cout;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f_q       <= '0;
      fsel_q    <= 1'b0;
      csel_q    <= 1'b0;
      ucin_q    <= 1'b0;
      upd_c_q   <= 1'b0;
      rsp_y_q   <= '0;
      rsp_err_q <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f_q       <= f_d;
      fsel_q    <= fsel_d;
      csel_q    <= csel_d;
      ucin_q    <= ucin_d;
      upd_c_q   <= upd_c_d;
      rsp_y_q   <= rsp_y_d;
      rsp_err_q <= rsp_err_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
    end
  end

  // Gated by reset_n so the sequencer reports not-ready while held in reset.
  assign req_ready = (state_q == StIdle) && reset_n;
  assign alu_fyoe  = (state_q == StDrive);
  assign rsp_valid = (state_q == StResp);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_f     = f_q;
  assign alu_fsel  = fsel_q;
  assign alu_csel  = csel_q;
  assign alu_ucin  = ucin_q;
  assign alu_fcin  = flag_c_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;

endmodule
